// File: rtl/cnn_frame_sequencer.sv
// Frame-injection and result-checking controller in front of a CNN core.
// The host fills a frame buffer and a golden value, then pulses go. The block pulses
// cnn_start, streams the frame with valid/ready, waits for the core's result under a
// watchdog, and reports a pass/fail/timeout verdict with saturating counters.
module cnn_frame_sequencer #(
    parameter int unsigned IMG_WIDTH   = 32,
    parameter int unsigned IMG_HEIGHT  = 32,
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned RES_W       = 48,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned IMG_SIZE   = IMG_WIDTH * IMG_HEIGHT,
    localparam int unsigned AW         = $clog2(IMG_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [RES_W-1:0] golden_in,
    input  logic             go,
    input  logic             loop_en,
    output logic             cnn_start,
    output logic             cnn_pixel_valid,
    output logic [PIX_W-1:0] cnn_pixel,
    input  logic             cnn_pixel_ready,
    input  logic             cnn_result_valid,
    input  logic [RES_W-1:0] cnn_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [RES_W-1:0] result_out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic signed [RES_W-1:0] golden_q, golden_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic [RES_W-1:0]        result_q, result_d;
    logic [CNT_W-1:0]        pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]        fail_cnt_q, fail_cnt_d;

    logic [PIX_W-1:0]        mem [IMG_SIZE];
    logic [PIX_W-1:0]        rd_data_q;
    logic [AW-1:0]           rd_addr;
    logic                    mem_we;

    // The host may only touch the buffer while idle, so streaming never races a write.
    assign mem_we = wr_en && (state_q == ST_IDLE);

    // Buffer: synchronous write port and synchronous read port, no reset on contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    // Next-state logic. The read address always looks one cycle ahead (the index that
    // will be presented next cycle), so a stall simply re-reads the held pixel and an
    // accepted pixel is replaced by its successor with no bubble.
    always_comb begin
        state_d    = state_q;
        golden_d   = golden_q;
        idx_d      = idx_q;
        wd_d       = '0;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        result_d   = result_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        rd_addr    = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d  = ST_START;
                    golden_d = golden_in;
                end
            end
            ST_START: begin
                idx_d   = '0;
                rd_addr = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (cnn_pixel_ready) begin
                    if (idx_q == AW'(IMG_SIZE - 1)) begin
                        state_d = ST_WAIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                rd_addr = idx_d;
            end
            ST_WAIT: begin
                // A result arriving on the last watchdog cycle takes priority.
                if (cnn_result_valid) begin
                    state_d   = ST_CHECK;
                    result_d  = cnn_result;
                    timeout_d = 1'b0;
                    pass_d    = ($signed(cnn_result) == golden_q);
                    if ($signed(cnn_result) == golden_q) begin
                        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
                    end else begin
                        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = ST_CHECK;
                    result_d  = '0;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = loop_en ? ST_START : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and verdict state, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            golden_q   <= '0;
            idx_q      <= '0;
            wd_q       <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            result_q   <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            golden_q   <= golden_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            result_q   <= result_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Outputs decode directly from state so reset forces them low immediately.
    always_comb begin
        busy            = (state_q != ST_IDLE);
        cnn_start       = (state_q == ST_START);
        cnn_pixel_valid = (state_q == ST_STREAM);
        cnn_pixel       = (state_q == ST_STREAM) ? rd_data_q : '0;
        done            = (state_q == ST_CHECK);
        pass            = pass_q;
        timeout         = timeout_q;
        result_out      = result_q;
        pass_cnt        = pass_cnt_q;
        fail_cnt        = fail_cnt_q;
    end

endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
Synthesizable frame-injection and result-checking controller placed in front of CNN_TOP. The host loads one image frame into an internal buffer and a golden value into a register, then issues a go pulse. The block pulses start, streams the frame to the CNN core with a valid/ready handshake, and waits for the core's result under a watchdog. It then compares the result against the golden value, reports pass/fail/timeout, and keeps running counters. It generalises frame size, pixel width and result width, and adds backpressure, looped runs and hardware verdicts.

Parameters:
IMG_WIDTH, 32, pixels per line
IMG_HEIGHT, 32, lines per frame; IMG_SIZE = IMG_WIDTH*IMG_HEIGHT, AW = clog2(IMG_SIZE)
PIX_W, 8, pixel width
RES_W, 48, signed result width
TIMEOUT_CYC, 50000, maximum cycles spent in WAIT before a timeout is declared
CNT_W, 16, pass/fail counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  frame buffer write strobe
wr_addr  in  AW  buffer write address
wr_data  in  PIX_W  buffer write data
golden_in  in  RES_W  signed expected result, sampled when go is accepted
go  in  1  run request, single-cycle pulse
loop_en  in  1  re-run the frame continuously while high
cnn_start  out  1  start pulse to core
cnn_pixel_valid  out  1  pixel valid to core
cnn_pixel  out  PIX_W  pixel to core
cnn_pixel_ready  in  1  core accepts pixel
cnn_result_valid  in  1  core result strobe
cnn_result  in  RES_W  signed core result
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle verdict pulse
pass  out  1  last verdict: result equals golden
timeout  out  1  last run timed out
result_out  out  RES_W  last captured result (0 on timeout)
pass_cnt  out  CNT_W  saturating count of passes
fail_cnt  out  CNT_W  saturating count of mismatches plus timeouts

Behaviour:
- Reset: every output goes to 0 immediately; state goes to IDLE; golden register, pixel index and watchdog clear. Buffer contents are not cleared. The same applies to reset asserted mid-run.
- Buffer: IMG_SIZE x PIX_W, one synchronous write port and one synchronous read port. Writes are honoured only in IDLE. Writes while busy are dropped.
- States: IDLE, START, STREAM, WAIT, CHECK.
- IDLE → START when go=1 at a clock edge; golden_in is latched on that edge. A go received while busy is ignored.
- START: lasts one cycle with cnn_start=1. Buffer address 0 is read during this cycle. Next state is STREAM.
- STREAM:
  - cnn_pixel_valid=1 from the first STREAM cycle; cnn_pixel = buf[0] in that cycle.
  - A transfer occurs when valid & ready. cnn_pixel and valid hold stable while ready=0.
  - No bubbles: with ready held high, one pixel transfers every cycle, in address order 0..IMG_SIZE-1. Prefetch and skid are required to meet this.
  - After the IMG_SIZE-th transfer, valid=0 on the next cycle and state goes to WAIT.
- WAIT:
  - The watchdog counts cycles spent in WAIT.
  - cnn_result_valid=1 captures cnn_result into result_out on that edge and moves to CHECK.
  - If the watchdog reaches TIMEOUT_CYC-1 with no result, timeout is set, result_out=0, and state moves to CHECK.
  - If result_valid coincides with the final watchdog count, the result wins and no timeout is flagged.
  - cnn_result_valid outside WAIT is ignored.
- CHECK: lasts one cycle. done=1. pass = (result_out == golden), a signed full-width compare, forced to 0 on timeout. Exactly one counter increments, and both saturate at all ones. pass and timeout hold until the next CHECK.
- After CHECK: if loop_en=1 the state goes to START, reusing the latched golden value; otherwise it goes to IDLE.
- Latency, with ready constantly high and a go pulse at edge 0:
  - cnn_start is high during cycle 1.
  - pixel 0 is valid during cycle 2.
  - the last pixel is valid during cycle IMG_SIZE+1.
  - done follows result capture by one cycle.

Test Plan:
- Default parameters, ready=1, buf[a]=a[7:0], golden=-12345, core model returns -12345 five cycles after the last pixel → one cnn_start pulse; 1024 contiguous transfers with pixels 0..255 repeating; done=1, pass=1, pass_cnt=1, busy low after CHECK.
- golden=100, core returns 99 → pass=0, timeout=0, result_out=99, fail_cnt=1.
- ready toggling 1,0,0,1 repeating during STREAM → cnn_pixel stable whenever ready=0; exactly 1024 accepted; order and values match the buffer; no duplicates.
- TIMEOUT_CYC=100, core never responds → done exactly 100 cycles after WAIT entry; timeout=1, pass=0, result_out=0, fail_cnt=1. Also: result_valid on watchdog cycle 99 → pass path, timeout=0.
- loop_en=1 for three runs with a matching core, then dropped → three cnn_start pulses, pass_cnt=3, return to IDLE; go pulses while busy have no effect.
- rst asserted at transfer 500 → all outputs 0 asynchronously; after release, wr_en in IDLE still works; a new go streams from pixel 0 with the earlier buffer data intact.
